dca_matrix_lsu_rdata_gather: RTL and testbench

Read-side counterpart of the matrix LSU write-data streamer. It accepts one burst descriptor per AXI read transaction, collects the R-channel beats of that burst into a memory-row-buffer-wide register, and presents the assembled row downstream with per-byte enables. It sits between the LSU's AXI read port and the matrix row buffer.

---
 rtl/dca_matrix_lsu_rdata_gather_if.sv | 48 ++++
 rtl/dca_matrix_lsu_rdata_gather.sv | 148 ++++++++++++++
 tb/tb_dca_matrix_lsu_rdata_gather.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dca_matrix_lsu_rdata_gather_if.sv
// Bundle of descriptor, AXI R-channel and assembled-row handshakes for the rdata gather block.
`default_nettype none

interface dca_matrix_lsu_rdata_gather_if #(
  parameter int BW_AXI_DATA      = 32,
  parameter int MAX_NUM_AXI_DATA = 4,
  parameter int BW_AXI_ALEN      = 8
);
  localparam int BW_ROW    = BW_AXI_DATA * MAX_NUM_AXI_DATA;
  localparam int BW_ROW_BE = BW_ROW / 8;

  logic                   txn_valid;
  logic                   txn_ready;
  logic [BW_AXI_ALEN-1:0] txn_alen;
  logic                   txn_tag;

  logic                   rvalid;
  logic                   rready;
  logic [BW_AXI_DATA-1:0] rdata;
  logic [1:0]             rresp;
  logic                   rlast;

  logic                   row_valid;
  logic                   row_ready;
  logic [BW_ROW-1:0]      row_data;
  logic [BW_ROW_BE-1:0]   row_byte_enable;
  logic                   row_tag;
  logic                   row_error;

  // master: the LSU/AXI/row-buffer environment; slave: the gather block itself
  modport master (
    output txn_valid, txn_alen, txn_tag,
    output rvalid, rdata, rresp, rlast,
    output row_ready,
    input  txn_ready, rready,
    input  row_valid, row_data, row_byte_enable, row_tag, row_error
  );

  modport slave (
    input  txn_valid, txn_alen, txn_tag,
    input  rvalid, rdata, rresp, rlast,
    input  row_ready,
    output txn_ready, rready,
    output row_valid, row_data, row_byte_enable, row_tag, row_error
  );
endinterface

`default_nettype wire

// File: rtl/dca_matrix_lsu_rdata_gather.sv
// Collects the R beats of one AXI read burst into a row-wide register and
// presents the row with per-byte enables, a carried tag and an error flag.
`default_nettype none

module dca_matrix_lsu_rdata_gather #(
  parameter int BW_AXI_DATA      = 32,
  parameter int MAX_NUM_AXI_DATA = 4,
  parameter int BW_AXI_ALEN      = 8
) (
  input  wire logic                         clk,
  input  wire logic                         rstnn,
  input  wire logic                         clear,
  dca_matrix_lsu_rdata_gather_if.slave      bus
);
  localparam int BW_ROW    = BW_AXI_DATA * MAX_NUM_AXI_DATA;
  localparam int BW_ROW_BE = BW_ROW / 8;
  localparam int BEAT_BE   = BW_AXI_DATA / 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  state_t                 state_q,     state_d;
  logic [BW_AXI_ALEN-1:0] idx_q,       idx_d;
  logic [BW_AXI_ALEN-1:0] alen_q,      alen_d;
  logic                   tag_q,       tag_d;
  logic                   err_q,       err_d;
  logic [BW_ROW-1:0]      data_q,      data_d;
  logic [BW_ROW_BE-1:0]   be_q,        be_d;
  logic                   txn_ready_q, txn_ready_d;
  logic                   rready_q,    rready_d;
  logic                   row_valid_q, row_valid_d;

  logic r_fire;
  logic last_by_count;

  assign r_fire        = bus.rvalid && rready_q;
  assign last_by_count = (idx_q == alen_q);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    alen_d      = alen_q;
    tag_d       = tag_q;
    err_d       = err_q;
    data_d      = data_q;
    be_d        = be_q;
    txn_ready_d = txn_ready_q;
    rready_d    = rready_q;
    row_valid_d = row_valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.txn_valid) begin
          alen_d      = bus.txn_alen;
          tag_d       = bus.txn_tag;
          data_d      = '0;
          be_d        = '0;
          err_d       = 1'b0;
          idx_d       = '0;
          state_d     = ST_COLLECT;
          txn_ready_d = 1'b0;
          rready_d    = 1'b1;
        end
      end

      ST_COLLECT: begin
        if (r_fire) begin
          // Beats past the last slot are counted but never land in the row.
          for (int k = 0; k < MAX_NUM_AXI_DATA; k++) begin
            if (idx_q == BW_AXI_ALEN'(k)) begin
              data_d[k*BW_AXI_DATA +: BW_AXI_DATA] = bus.rdata;
              be_d[k*BEAT_BE +: BEAT_BE]           = '1;
            end
          end
          if (bus.rresp[1] || (bus.rlast != last_by_count)) begin
            err_d = 1'b1;
          end
          idx_d = idx_q + BW_AXI_ALEN'(1);
          // The beat count alone closes the burst; rlast only feeds the error flag.
          if (last_by_count) begin
            state_d     = ST_HOLD;
            rready_d    = 1'b0;
            row_valid_d = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (bus.row_ready) begin
          state_d     = ST_IDLE;
          row_valid_d = 1'b0;
          txn_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        txn_ready_d = 1'b1;
        rready_d    = 1'b0;
        row_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstnn || clear) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      alen_q      <= '0;
      tag_q       <= 1'b0;
      err_q       <= 1'b0;
      data_q      <= '0;
      be_q        <= '0;
      txn_ready_q <= 1'b1;
      rready_q    <= 1'b0;
      row_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      alen_q      <= alen_d;
      tag_q       <= tag_d;
      err_q       <= err_d;
      data_q      <= data_d;
      be_q        <= be_d;
      txn_ready_q <= txn_ready_d;
      rready_q    <= rready_d;
      row_valid_q <= row_valid_d;
    end
  end

  assign bus.txn_ready       = txn_ready_q;
  assign bus.rready          = rready_q;
  assign bus.row_valid       = row_valid_q;
  assign bus.row_data        = data_q;
  assign bus.row_byte_enable = be_q;
  assign bus.row_tag         = tag_q;
  assign bus.row_error       = err_q;

  // Only the SLVERR/DECERR bit of rresp matters here.
  logic unused_rresp;
  assign unused_rresp = bus.rresp[0];

endmodule

`default_nettype wire

// File: tb/tb_dca_matrix_lsu_rdata_gather.sv
// Scoreboard bench for dca_matrix_lsu_rdata_gather: directed cases plus randomized bursts.
`default_nettype none

module tb_dca_matrix_lsu_rdata_gather;
  localparam int BW   = 32;
  localparam int MAXN = 4;
  localparam int BWA  = 8;
  localparam int BWR  = BW * MAXN;
  localparam int BWBE = BWR / 8;

  typedef struct {
    logic [BWR-1:0]  data;
    logic [BWBE-1:0] be;
    logic            tag;
    logic            err;
  } exp_t;

  logic clk;
  logic rstnn;
  logic clear;

  dca_matrix_lsu_rdata_gather_if #(.BW_AXI_DATA(BW), .MAX_NUM_AXI_DATA(MAXN), .BW_AXI_ALEN(BWA)) bus ();

  dca_matrix_lsu_rdata_gather #(.BW_AXI_DATA(BW), .MAX_NUM_AXI_DATA(MAXN), .BW_AXI_ALEN(BWA)) dut (
    .clk   (clk),
    .rstnn (rstnn),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];

  bit rr_random = 1'b0;
  bit rr_manual = 1'b0;

  logic [BW-1:0] b_data [0:15];
  logic [1:0]    b_resp [0:15];
  logic          b_last [0:15];

  task automatic chk(input string name, input bit ok, input logic [BWR-1:0] act, input logic [BWR-1:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
  endtask

  // Expected row straight from the burst contents: slot i gets beat i while slots remain.
  function automatic exp_t model(input int alen, input bit tag);
    exp_t e;
    e.data = '0;
    e.be   = '0;
    e.tag  = tag;
    e.err  = 1'b0;
    for (int i = 0; i <= alen; i++) begin
      if (i < MAXN) begin
        e.data[i*BW +: BW]     = b_data[i];
        e.be[i*(BW/8) +: BW/8] = '1;
      end
      if (b_resp[i][1]) e.err = 1'b1;
      if (b_last[i] != (i == alen)) e.err = 1'b1;
    end
    return e;
  endfunction

  // Only driver of row_ready; runs after the main process updates rr_manual at +1.
  always @(posedge clk) begin
    #2;
    bus.row_ready = rr_random ? ($urandom_range(0, 3) != 0) : rr_manual;
  end

  // Monitor: protocol sanity every cycle, scoreboard compare on each row handshake.
  initial begin
    logic           hold_prev;
    logic [BWR-1:0] p_data;
    logic [BWBE-1:0] p_be;
    logic           p_tag, p_err;
    exp_t           e;
    hold_prev = 1'b0;
    p_data = '0; p_be = '0; p_tag = 1'b0; p_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rstnn && !clear) begin
        chk("onehot_ctrl", ($countones({bus.txn_ready, bus.rready, bus.row_valid}) == 1),
            {bus.txn_ready, bus.rready, bus.row_valid}, 3'b000);
      end
      if (bus.row_valid) begin
        if (hold_prev) begin
          chk("hold_stable", (bus.row_data == p_data) && (bus.row_byte_enable == p_be)
              && (bus.row_tag == p_tag) && (bus.row_error == p_err), bus.row_data, p_data);
        end
        if (bus.row_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_row", 1'b0, bus.row_data, '0);
          end else begin
            e = exp_q.pop_front();
            chk("row_data", bus.row_data == e.data, bus.row_data, e.data);
            chk("row_be",   bus.row_byte_enable == e.be, bus.row_byte_enable, e.be);
            chk("row_tag",  bus.row_tag == e.tag, bus.row_tag, e.tag);
            chk("row_err",  bus.row_error == e.err, bus.row_error, e.err);
          end
        end
      end
      hold_prev = bus.row_valid && !bus.row_ready;
      p_data = bus.row_data; p_be = bus.row_byte_enable; p_tag = bus.row_tag; p_err = bus.row_error;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // All driver tasks start and end at posedge+1.
  task automatic send_txn(input int alen, input bit tag);
    int n;
    bus.txn_valid = 1'b1;
    bus.txn_alen  = BWA'(alen);
    bus.txn_tag   = tag;
    n = 0;
    @(negedge clk);
    while (!bus.txn_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("txn_ready_timeout", 1'b0, 0, 1);
    @(posedge clk); #1;
    bus.txn_valid = 1'b0;
    chk("rready_after_txn", bus.rready == 1'b1 && bus.txn_ready == 1'b0, bus.rready, 1);
  endtask

  task automatic send_beat(input logic [BW-1:0] d, input logic [1:0] resp, input bit last,
                           input int gap, input bit is_final);
    int n;
    bus.rvalid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.rvalid = 1'b1;
    bus.rdata  = d;
    bus.rresp  = resp;
    bus.rlast  = last;
    n = 0;
    @(negedge clk);
    while (!bus.rready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("rready_timeout", 1'b0, 0, 1);
    @(posedge clk); #1;
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    if (is_final) begin
      chk("row_valid_after_final", bus.row_valid == 1'b1 && bus.rready == 1'b0,
          {bus.row_valid, bus.rready}, 2'b10);
    end
  endtask

  task automatic run_burst(input int alen, input bit tag, input int gap_max, input bit push);
    if (push) exp_q.push_back(model(alen, tag));
    send_txn(alen, tag);
    for (int i = 0; i <= alen; i++) begin
      send_beat(b_data[i], b_resp[i], b_last[i], $urandom_range(0, gap_max), i == alen);
    end
  endtask

  task automatic set_beats(input int alen, input logic [BW-1:0] base);
    for (int i = 0; i <= alen; i++) begin
      b_data[i] = base * (i + 1);
      b_resp[i] = 2'b00;
      b_last[i] = (i == alen);
    end
  endtask

  task automatic release_row();
    rr_manual = 1'b1;
    @(posedge clk); #1;
    rr_manual = 1'b0;
    @(negedge clk);
    chk("txn_ready_after_row", bus.txn_ready == 1'b1 && bus.row_valid == 1'b0, bus.txn_ready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    rstnn = 1'b0; clear = 1'b0;
    bus.txn_valid = 1'b0; bus.txn_alen = '0; bus.txn_tag = 1'b0;
    bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 1'b0;
    bus.row_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstnn = 1'b1;

    // Reset and idle
    @(negedge clk);
    chk("rst_txn_ready", bus.txn_ready == 1'b1, bus.txn_ready, 1);
    chk("rst_rready",    bus.rready == 1'b0, bus.rready, 0);
    chk("rst_row_valid", bus.row_valid == 1'b0, bus.row_valid, 0);
    chk("rst_row_outs",  {bus.row_data, bus.row_byte_enable, bus.row_tag, bus.row_error} == '0,
        bus.row_data, 0);
    @(posedge clk); #1;
    bus.rvalid = 1'b1; bus.rdata = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1 bus.rvalid = 1'b0;
    chk("idle_rvalid_ignored", bus.row_data == '0 && bus.row_byte_enable == '0, bus.row_data, 0);

    // Full 4-beat burst
    set_beats(3, 32'h11111111);
    run_burst(3, 1'b1, 0, 1'b1);
    chk("full_data", bus.row_data == 128'h44444444_33333333_22222222_11111111, bus.row_data,
        128'h44444444_33333333_22222222_11111111);
    chk("full_be", bus.row_byte_enable == 16'hFFFF, bus.row_byte_enable, 16'hFFFF);
    release_row();

    // Short burst with 5 cycles of backpressure
    set_beats(1, 32'h0);
    b_data[0] = 32'hA; b_data[1] = 32'hB;
    run_burst(1, 1'b0, 0, 1'b1);
    chk("short_be", bus.row_byte_enable == 16'h00FF, bus.row_byte_enable, 16'h00FF);
    chk("short_upper_zero", bus.row_data[127:64] == 64'h0, bus.row_data[127:64], 0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_rready_low", bus.rready == 1'b0 && bus.row_valid == 1'b1, {bus.rready, bus.row_valid}, 2'b01);
    end
    @(posedge clk); #1;
    release_row();

    // SLVERR on beat 1 of 2
    set_beats(1, 32'h5);
    b_resp[1] = 2'b10;
    run_burst(1, 1'b0, 1, 1'b1);
    chk("slverr_flag", bus.row_error == 1'b1, bus.row_error, 1);
    release_row();

    // Early rlast on beat 0 of 3: still collects all three
    set_beats(2, 32'h77);
    b_last[0] = 1'b1;
    run_burst(2, 1'b1, 1, 1'b1);
    chk("early_rlast_err", bus.row_error == 1'b1, bus.row_error, 1);
    chk("early_rlast_be", bus.row_byte_enable == 16'h0FFF, bus.row_byte_enable, 16'h0FFF);
    release_row();

    // Overlength burst: six beats, four slots
    set_beats(5, 32'h01010101);
    run_burst(5, 1'b0, 0, 1'b1);
    chk("over_be", bus.row_byte_enable == 16'hFFFF, bus.row_byte_enable, 16'hFFFF);
    chk("over_slot3", bus.row_data[127:96] == 32'h04040404, bus.row_data[127:96], 32'h04040404);
    release_row();

    // Mid-burst clear after 2 of 4 beats
    set_beats(3, 32'h9);
    send_txn(3, 1'b1);
    send_beat(b_data[0], 2'b00, 1'b0, 0, 1'b0);
    send_beat(b_data[1], 2'b00, 1'b0, 0, 1'b0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    chk("clr_idle", bus.txn_ready == 1'b1 && bus.rready == 1'b0 && bus.row_valid == 1'b0,
        {bus.txn_ready, bus.rready, bus.row_valid}, 3'b100);
    chk("clr_zero", {bus.row_data, bus.row_byte_enable, bus.row_tag, bus.row_error} == '0, bus.row_data, 0);
    @(posedge clk); #1;
    set_beats(0, 32'hCAFE0001);
    run_burst(0, 1'b0, 0, 1'b1);
    chk("one_beat_be", bus.row_byte_enable == 16'h000F, bus.row_byte_enable, 16'h000F);
    release_row();

    // Randomized bursts with random R gaps and downstream backpressure
    rr_random = 1'b1;
    for (int b = 0; b < 60; b++) begin
      int alen;
      alen = $urandom_range(0, 6);
      for (int i = 0; i <= alen; i++) begin
        b_data[i] = $urandom;
        b_resp[i] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
        b_last[i] = (i == alen) ^ ($urandom_range(0, 9) == 0);
      end
      run_burst(alen, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? 2 : 0, 1'b1);
    end

    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin @(posedge clk); n++; end
      chk("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
